// File: rtl/regfile_sb_if.sv
// regfile_sb port bundle: writeback, two read ports and the
// issue/scoreboard handshake between decode and the register file.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [XLEN-1:0] D;
  logic [AW-1:0]   A_D;
  logic            write_enable;

  logic [AW-1:0]   A_Q0;
  logic [AW-1:0]   A_Q1;
  logic [XLEN-1:0] Q0;
  logic [XLEN-1:0] Q1;
  logic            BUSY_Q0;
  logic            BUSY_Q1;

  logic            issue_valid;
  logic [AW-1:0]   A_I;
  logic            issue_ready;
  logic            flush;
  logic [AW:0]     busy_count;

  modport master (
    output D, A_D, write_enable,
    output A_Q0, A_Q1,
    output issue_valid, A_I, flush,
    input  Q0, Q1, BUSY_Q0, BUSY_Q1,
    input  issue_ready, busy_count
  );

  modport slave (
    input  D, A_D, write_enable,
    input  A_Q0, A_Q1,
    input  issue_valid, A_I, flush,
    output Q0, Q1, BUSY_Q0, BUSY_Q1,
    output issue_ready, busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with r0 hard-wired to zero, writeback forwarding on both
// read ports and a pending-write scoreboard for RAW/WAW stalls.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic         CLK,
  input  logic         RES,
  regfile_sb_if.slave  rf
);
  localparam int N  = 2 ** AW;
  localparam int CW = AW + 1;

  logic [XLEN-1:0] regs_q [N];
  logic [N-1:0]    busy_q;
  logic [N-1:0]    busy_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic wr_hit;
  logic iss_acc;
  logic inc;
  logic dec;

  assign wr_hit = rf.write_enable && (rf.A_D != '0);

  // A reservation may replace one being retired in the same cycle.
  assign rf.issue_ready = (rf.A_I == '0)
                        || !busy_q[rf.A_I]
                        || (wr_hit && (rf.A_D == rf.A_I));

  assign iss_acc = rf.issue_valid && rf.issue_ready
                && (rf.A_I != '0) && !rf.flush;

  assign inc = iss_acc && !busy_q[rf.A_I];
  assign dec = wr_hit && busy_q[rf.A_D]
            && !(iss_acc && (rf.A_I == rf.A_D));

  always_comb begin
    busy_d = busy_q;
    if (wr_hit)
      busy_d[rf.A_D] = 1'b0;
    if (iss_acc)
      busy_d[rf.A_I] = 1'b1;
    if (rf.flush)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rf.flush)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      for (int i = 0; i < N; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_hit)
        regs_q[rf.A_D] <= rf.D;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rf.busy_count = cnt_q;

  always_comb begin
    rf.Q0      = regs_q[rf.A_Q0];
    rf.BUSY_Q0 = busy_q[rf.A_Q0];
    unique case (1'b1)
      (rf.A_Q0 == '0): begin
        rf.Q0      = '0;
        rf.BUSY_Q0 = 1'b0;
      end
      (wr_hit && (rf.A_D == rf.A_Q0)): begin
        rf.Q0      = rf.D;
        rf.BUSY_Q0 = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rf.Q1      = regs_q[rf.A_Q1];
    rf.BUSY_Q1 = busy_q[rf.A_Q1];
    unique case (1'b1)
      (rf.A_Q1 == '0): begin
        rf.Q1      = '0;
        rf.BUSY_Q1 = 1'b0;
      end
      (wr_hit && (rf.A_D == rf.A_Q1)): begin
        rf.Q1      = rf.D;
        rf.BUSY_Q1 = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, forwarding, scoreboard RAW/WAW,
// flush and mid-operation reset, all against hand-computed values.
module tb_regfile_sb;
  logic CLK;
  logic RES;

  regfile_sb_if #(.XLEN(32), .AW(5)) rf ();

  regfile_sb #(.XLEN(32), .AW(5)) dut (
    .CLK (CLK),
    .RES (RES),
    .rf  (rf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    rf.write_enable = 1'b0;
    rf.issue_valid  = 1'b0;
    rf.flush        = 1'b0;
    RES             = 1'b0;
  endtask

  initial begin
    rf.D = '0; rf.A_D = '0; rf.write_enable = 1'b0;
    rf.A_Q0 = '0; rf.A_Q1 = '0;
    rf.issue_valid = 1'b0; rf.A_I = '0; rf.flush = 1'b0;
    RES = 1'b1;
    tick();
    idle();

    // reset state
    rf.A_Q0 = 5'd0; rf.A_Q1 = 5'd1; rf.A_I = 5'd7;
    #1;
    chk("rst_q0_a0", rf.Q0, 0);
    chk("rst_bq0_a0", rf.BUSY_Q0, 0);
    chk("rst_q1_a1", rf.Q1, 0);
    chk("rst_bq1_a1", rf.BUSY_Q1, 0);
    chk("rst_cnt", rf.busy_count, 0);
    chk("rst_ready", rf.issue_ready, 1);
    rf.A_Q0 = 5'd31;
    #1;
    chk("rst_q0_a31", rf.Q0, 0);
    chk("rst_bq0_a31", rf.BUSY_Q0, 0);

    // write with same-cycle forwarding
    rf.write_enable = 1'b1; rf.A_D = 5'd5;
    rf.D = 32'hDEADBEEF; rf.A_Q0 = 5'd5;
    #1;
    chk("fwd_q0", rf.Q0, 32'hDEADBEEF);
    chk("fwd_bq0", rf.BUSY_Q0, 0);
    tick();
    idle();
    #1;
    chk("wr_q0_held", rf.Q0, 32'hDEADBEEF);

    // write to r0 is ignored
    rf.write_enable = 1'b1; rf.A_D = 5'd0;
    rf.D = 32'h123; rf.A_Q0 = 5'd0;
    #1;
    chk("r0_fwd_q0", rf.Q0, 0);
    tick();
    idle();
    #1;
    chk("r0_q0", rf.Q0, 0);

    // RAW scoreboard on r7
    rf.issue_valid = 1'b1; rf.A_I = 5'd7;
    #1;
    chk("raw_ready0", rf.issue_ready, 1);
    tick();
    idle();
    rf.A_Q1 = 5'd7;
    #1;
    chk("raw_bq1", rf.BUSY_Q1, 1);
    chk("raw_cnt1", rf.busy_count, 1);
    chk("raw_waw", rf.issue_ready, 0);
    rf.write_enable = 1'b1; rf.A_D = 5'd7; rf.D = 32'd42;
    #1;
    chk("raw_wb_bq1", rf.BUSY_Q1, 0);
    chk("raw_wb_q1", rf.Q1, 42);
    chk("raw_wb_ready", rf.issue_ready, 1);
    tick();
    idle();
    #1;
    chk("raw_cnt0", rf.busy_count, 0);
    chk("raw_q1", rf.Q1, 42);
    chk("raw_bq1_clr", rf.BUSY_Q1, 0);

    // r0 issue: handshake accepted, no state change
    rf.issue_valid = 1'b1; rf.A_I = 5'd0;
    #1;
    chk("i0_ready", rf.issue_ready, 1);
    tick();
    idle();
    #1;
    chk("i0_cnt", rf.busy_count, 0);

    // same-cycle issue and writeback on busy r9
    rf.issue_valid = 1'b1; rf.A_I = 5'd9;
    tick();
    idle();
    #1;
    chk("r9_cnt1", rf.busy_count, 1);
    rf.issue_valid = 1'b1; rf.A_I = 5'd9;
    rf.write_enable = 1'b1; rf.A_D = 5'd9; rf.D = 32'd99;
    #1;
    chk("r9_ready", rf.issue_ready, 1);
    tick();
    idle();
    rf.A_Q0 = 5'd9;
    #1;
    chk("r9_bq0", rf.BUSY_Q0, 1);
    chk("r9_q0", rf.Q0, 99);
    chk("r9_cnt", rf.busy_count, 1);
    rf.write_enable = 1'b1; rf.A_D = 5'd9; rf.D = 32'd100;
    tick();
    idle();
    #1;
    chk("r9_retire_cnt", rf.busy_count, 0);

    // flush
    for (int i = 1; i <= 4; i++) begin
      rf.issue_valid = 1'b1; rf.A_I = 5'(i);
      tick();
    end
    idle();
    #1;
    chk("fl_cnt4", rf.busy_count, 4);
    rf.flush = 1'b1;
    rf.write_enable = 1'b1; rf.A_D = 5'd2; rf.D = 32'd7;
    rf.issue_valid = 1'b1; rf.A_I = 5'd10;
    #1;
    chk("fl_ready10", rf.issue_ready, 1);
    tick();
    idle();
    rf.A_Q0 = 5'd10; rf.A_Q1 = 5'd2;
    #1;
    chk("fl_cnt0", rf.busy_count, 0);
    chk("fl_bq0_r10", rf.BUSY_Q0, 0);
    chk("fl_q1_r2", rf.Q1, 7);
    chk("fl_bq1_r2", rf.BUSY_Q1, 0);
    rf.A_Q0 = 5'd1;
    #1;
    chk("fl_bq0_r1", rf.BUSY_Q0, 0);

    // reset mid-operation
    for (int i = 11; i <= 13; i++) begin
      rf.issue_valid = 1'b1; rf.A_I = 5'(i);
      tick();
    end
    idle();
    rf.write_enable = 1'b1; rf.A_D = 5'd3; rf.D = 32'd33;
    tick();
    idle();
    rf.A_Q0 = 5'd3; rf.A_Q1 = 5'd11;
    #1;
    chk("mr_cnt3", rf.busy_count, 3);
    chk("mr_q0_pre", rf.Q0, 33);
    chk("mr_bq1_pre", rf.BUSY_Q1, 1);
    RES = 1'b1;
    rf.write_enable = 1'b1; rf.A_D = 5'd14; rf.D = 32'd55;
    tick();
    idle();
    rf.A_I = 5'd11;
    #1;
    chk("mr_cnt0", rf.busy_count, 0);
    chk("mr_q0_r3", rf.Q0, 0);
    chk("mr_bq1_r11", rf.BUSY_Q1, 0);
    chk("mr_ready", rf.issue_ready, 1);
    rf.A_Q1 = 5'd14; rf.A_Q0 = 5'd2;
    #1;
    chk("mr_q1_r14", rf.Q1, 0);
    chk("mr_q0_r2", rf.Q0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
